// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
//   Shared definitions for the serial-load GCD core, its requester and the
//   requester's bench: the default operand width and the requester FSM states.
// -----------------------------------------------------------------------------
package gcd_pkg;

    localparam int GCD_WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } gcd_state_t;

endpackage : gcd_pkg

// File: rtl/gcd_requester.sv
// -----------------------------------------------------------------------------
// gcd_requester
//   Initiator for the serial-load GCD core. Accepts one operand pair on a
//   valid/ready request port, drives the core (start pulse with A, then B),
//   waits for core_done, and returns the result on a valid/ready response port.
//   Zero operands never reach the core: gcd(x,0)=x is answered directly.
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   A valid is held (with stable payload) until its transfer; ready may depend
//   on state only, never on the matching valid.
//
// Parameters
//   WIDTH           operand/result width (matches the core data_in width)
//   TIMEOUT_CYCLES  WAIT-state cycle limit, used only with GCD_REQ_TIMEOUT_EN
//
// Optional feature macro: GCD_REQ_TIMEOUT_EN
//   Defined   : a counter in WAIT aborts after TIMEOUT_CYCLES cycles with
//               rsp_gcd=0, rsp_err=1.
//   Undefined : WAIT waits for core_done forever; rsp_err is constant 0.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_a, req_b               operands
//   rsp_valid/rsp_ready        response handshake
//   rsp_gcd, rsp_err           result and timeout-abort flag
//   core_start, core_data      core start pulse and serial data_in
//   core_done, core_result     core completion flag and A-register output
// -----------------------------------------------------------------------------
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH          = GCD_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result
);

    gcd_state_t       r_state;
    gcd_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_gcd;
    logic             r_wait_first;
    logic             w_accept;
    logic             w_zero_op;
    logic             w_done_ok;

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_zero_op = (req_a == '0) || (req_b == '0);

`ifdef GCD_REQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_expired;
    logic             w_timeout;

    // r_cnt holds the index of the current WAIT cycle (0 on entry).
    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        core_start  = 1'b0;
        core_data   = '0;
        w_done_ok   = 1'b0;
`ifdef GCD_REQ_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_zero_op ? RESP : LOAD_A;
                end
            end
            LOAD_A: begin
                core_start  = 1'b1;
                core_data   = r_a;
                w_state_nxt = LOAD_B;
            end
            LOAD_B: begin
                core_data   = r_b;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // The core may still show done from the previous operation
                // during the first WAIT cycle, so done only counts afterwards.
                w_done_ok = core_done && !r_wait_first;
                if (w_done_ok) begin
                    w_state_nxt = RESP;
                end
`ifdef GCD_REQ_TIMEOUT_EN
                else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Operand and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_gcd        <= '0;
            r_wait_first <= 1'b0;
        end else begin
            r_wait_first <= (r_state == LOAD_B);
            if (w_accept) begin
                r_a <= req_a;
                r_b <= req_b;
                // Zero bypass: gcd(x,0) = x, and gcd(0,0) = 0 falls out of it.
                if (req_a == '0) begin
                    r_gcd <= req_b;
                end else if (req_b == '0) begin
                    r_gcd <= req_a;
                end
            end
            if (w_done_ok) begin
                r_gcd <= core_result;
            end
`ifdef GCD_REQ_TIMEOUT_EN
            else if (w_timeout) begin
                r_gcd <= '0;
            end
`endif
        end
    end

    assign rsp_gcd = r_gcd;

`ifdef GCD_REQ_TIMEOUT_EN
    // ---------------------------------------------------------------------
    // WAIT-state timeout counter and error flag
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == LOAD_B) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept || w_done_ok) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule : gcd_requester

// File: tb/tb_gcd_requester.sv
// -----------------------------------------------------------------------------
// tb_gcd_requester
//   Bench for gcd_requester with a behavioural serial-load GCD core model.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   The core model keeps done high after finishing until the next start and
//   only clears it one cycle after B is loaded, so a stale done is visible in
//   the requester's first WAIT cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gcd_requester;
    import gcd_pkg::*;

    localparam int W  = GCD_WIDTH_DEFAULT;
    localparam int TO = 16;

    // ---------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ---------------------------------------------------------------------
    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a     = '0;
    logic [W-1:0] req_b     = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_gcd;
    logic         rsp_err;
    logic         core_start;
    logic [W-1:0] core_data;
    logic         core_done;
    logic [W-1:0] core_result;

    always #5 clk = ~clk;

    gcd_requester #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_gcd     (rsp_gcd),
        .rsp_err     (rsp_err),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_done   (core_done),
        .core_result (core_result)
    );

    // ---------------------------------------------------------------------
    // Behavioural GCD core (subtract/swap Euclid), independent of rst_n so
    // an abandoned operation keeps running until the next start.
    // ---------------------------------------------------------------------
    logic [W-1:0] m_a       = '0;
    logic [W-1:0] m_b       = '0;
    logic [1:0]   m_phase   = 2'd0;
    logic         m_done    = 1'b0;
    logic         stub_dead = 1'b0;

    always @(posedge clk) begin
        if (core_start) begin
            m_a     <= core_data;
            m_phase <= 2'd1;
        end else begin
            case (m_phase)
                2'd1: begin
                    m_b     <= core_data;
                    m_phase <= 2'd2;
                end
                2'd2: begin
                    m_done  <= 1'b0;
                    m_phase <= 2'd3;
                end
                2'd3: begin
                    if (m_b == '0) begin
                        m_done  <= 1'b1;
                        m_phase <= 2'd0;
                    end else if (m_a < m_b) begin
                        m_a <= m_b;
                        m_b <= m_a;
                    end else begin
                        m_a <= m_a - m_b;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_done   = m_done & ~stub_dead;
    assign core_result = m_a;

    // core_start pulses seen, counted on the sampling edge
    int start_cnt = 0;
    always @(negedge clk) begin
        if (core_start) start_cnt <= start_cnt + 1;
    end

    // ---------------------------------------------------------------------
    // Scoreboard counters and helpers
    // ---------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called on a falling edge; returns on the falling edge where rsp_valid=1.
    task automatic wait_rsp(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rsp_valid_within_budget", 32'(ok), 32'd1);
    endtask

    task automatic rsp_handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input bit byp, input int hold);
        int s0;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        s0        = start_cnt;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (byp) begin
            chk("bypass_one_cycle", 32'(rsp_valid), 32'd1);
        end else begin
            chk("load_a_start", 32'(core_start), 32'd1);
            chk("load_a_data", 32'(core_data), 32'(a));
            @(negedge clk);
            chk("load_b_start", 32'(core_start), 32'd0);
            chk("load_b_data", 32'(core_data), 32'(b));
        end
        wait_rsp(2000);
        chk("rsp_gcd", 32'(rsp_gcd), 32'(exp));
        chk("rsp_err", 32'(rsp_err), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_gcd", 32'(rsp_gcd), 32'(exp));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_handshake();
        chk("start_pulses", 32'(start_cnt - s0), byp ? 32'd0 : 32'd1);
    endtask

    // ---------------------------------------------------------------------
    // Directed vector table
    // ---------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           byp;
        int           hold;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{a: 16'd143,   b: 16'd78,    exp: 16'd13,    byp: 1'b0, hold: 0};
        vecs[1] = '{a: 16'd0,     b: 16'd25,    exp: 16'd25,    byp: 1'b1, hold: 0};
        vecs[2] = '{a: 16'd0,     b: 16'd0,     exp: 16'd0,     byp: 1'b1, hold: 0};
        vecs[3] = '{a: 16'd25,    b: 16'd0,     exp: 16'd25,    byp: 1'b1, hold: 2};
        vecs[4] = '{a: 16'd48,    b: 16'd18,    exp: 16'd6,     byp: 1'b0, hold: 5};
        vecs[5] = '{a: 16'd12,    b: 16'd8,     exp: 16'd4,     byp: 1'b0, hold: 0};
        vecs[6] = '{a: 16'd65535, b: 16'd65535, exp: 16'd65535, byp: 1'b0, hold: 0};
        vecs[7] = '{a: 16'd65534, b: 16'd32767, exp: 16'd32767, byp: 1'b0, hold: 1};
        vecs[8] = '{a: 16'd7,     b: 16'd5,     exp: 16'd1,     byp: 1'b0, hold: 0};

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_core_start", 32'(core_start), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_gcd", 32'(rsp_gcd), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_core_data", 32'(core_data), 32'd0);

        // ---------------- table-driven operations ----------------
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].byp, vecs[i].hold);
        end

        // ---------------- back-to-back with req_valid held ----------------
        begin
            int early;
            early = 0;
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = 16'd143;
            req_b     = 16'd78;
            @(negedge clk);
            req_a = 16'd12;
            req_b = 16'd8;
            for (int i = 0; i < 2000; i++) begin
                if (rsp_valid) break;
                if (req_ready) early++;
                @(negedge clk);
            end
            chk("b2b_no_early_accept", 32'(early), 32'd0);
            chk("b2b_first_valid", 32'(rsp_valid), 32'd1);
            chk("b2b_first_gcd", 32'(rsp_gcd), 32'd13);
            chk("b2b_ready_in_resp", 32'(req_ready), 32'd0);
            rsp_handshake();
            @(negedge clk);
            req_valid = 1'b0;
            chk("b2b_second_start", 32'(core_start), 32'd1);
            chk("b2b_second_data", 32'(core_data), 32'd12);
            wait_rsp(2000);
            chk("b2b_second_gcd", 32'(rsp_gcd), 32'd4);
            rsp_handshake();
        end

        // ---------------- reset during WAIT ----------------
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 16'd143;
        req_b     = 16'd78;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_in_wait", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_reset_core_start", 32'(core_start), 32'd0);
        chk("mid_reset_core_data", 32'(core_data), 32'd0);
        chk("mid_reset_rsp_gcd", 32'(rsp_gcd), 32'd0);
        chk("mid_reset_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        run_op(16'd9, 16'd6, 16'd3, 1'b0, 0);

`ifdef GCD_REQ_TIMEOUT_EN
        // ---------------- timeout with a dead core ----------------
        begin
            int n;
            n = 0;
            stub_dead = 1'b1;
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = 16'd143;
            req_b     = 16'd78;
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rsp_valid) break;
                n++;
            end
            chk("timeout_wait_cycles", 32'(n), 32'(TO));
            chk("timeout_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("timeout_rsp_err", 32'(rsp_err), 32'd1);
            chk("timeout_rsp_gcd", 32'(rsp_gcd), 32'd0);
            rsp_handshake();
            stub_dead = 1'b0;
            run_op(16'd12, 16'd8, 16'd4, 1'b0, 0);
        end
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gcd_requester
